// File: rtl/cn_link_host_pkg.sv
// Shared link symbol encodings, FSM states and defaults for the cn_core host link.
package cn_link_host_pkg;

  localparam int unsigned NWORDS_DEF = 13;

  typedef enum logic [8:0] {
    symbol_idle     = 9'h100,
    symbol_init     = 9'h101,
    symbol_start    = 9'h102,
    symbol_finished = 9'h103
  } io_link_symbols_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_START,
    ST_WAIT_FIN,
    ST_INIT,
    ST_XTX,
    ST_XRX,
    ST_DONE
  } host_state_t;

  // Control symbol that is not one of the four defined encodings.
  function automatic logic is_sym_err(input logic [8:0] sym);
    return sym[8] && (sym != symbol_idle) && (sym != symbol_init) &&
           (sym != symbol_start) && (sym != symbol_finished);
  endfunction

endpackage

// File: rtl/cn_link_rx_shift.sv
// 16-byte receive assembler: first data byte ends up in [127:120].
module cn_link_rx_shift
  import cn_link_host_pkg::*;
(
  input  logic         clk,
  input  logic         reset_l,
  input  logic [8:0]   i_s_in,
  input  logic         i_enable,
  input  logic         i_clear,
  output logic [127:0] o_word,
  output logic [4:0]   o_byte_count,
  output logic         o_word_valid,
  output logic         o_sym_err
);

  logic [127:0] r_word;
  logic [4:0]   r_count;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (i_enable && !i_s_in[8]) begin
      r_word  <= {r_word[119:0], i_s_in[7:0]};
      r_count <= r_count + 5'd1;
    end
  end

  assign o_word       = r_word;
  assign o_byte_count = r_count;
  assign o_word_valid = (r_count == 5'd16);
  assign o_sym_err    = is_sym_err(i_s_in);

endmodule

// File: rtl/cn_link_host.sv
// Host-side link master: loads the hash state into a cn_core, starts it,
// waits for FINISHED and reads the result words back over the 9-bit link.
module cn_link_host
  import cn_link_host_pkg::*;
#(
  parameter int unsigned NWORDS         = NWORDS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 16777215
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         wr_en,
  input  logic [3:0]   wr_addr,
  input  logic [127:0] wr_data,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_data,
  input  logic         go,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [8:0]   s_out,
  input  logic [8:0]   s_in
);

  localparam logic [3:0]  LAST_WORD = 4'(NWORDS - 1);
  localparam logic [4:0]  NW5       = 5'(NWORDS);
  localparam logic [23:0] TO_LAST   = 24'(TIMEOUT_CYCLES - 1);
  localparam logic        TO_EN     = (TIMEOUT_CYCLES != 0);

  host_state_t  r_state, w_state_nxt;
  logic [3:0]   r_word_idx, w_word_nxt;
  logic [3:0]   r_byte_idx, w_byte_nxt;
  logic [23:0]  r_cnt, w_cnt_nxt;
  logic [8:0]   r_s_out, w_s_out_nxt;
  logic         r_busy, w_busy_nxt;
  logic         r_done, w_done_nxt;
  logic         r_error;
  logic [127:0] r_buf [NWORDS];

  logic         w_go_acc, w_to_err, w_rx_clear, w_rx_wr, w_rx_en, w_timeout;
  logic [127:0] w_tx_word, w_rx_word;
  logic [7:0]   w_first_byte;
  logic [4:0]   w_rx_count;
  logic         w_rx_valid, w_sym_err;

  cn_link_rx_shift u_rx (
    .clk          (clk),
    .reset_l      (reset_l),
    .i_s_in       (s_in),
    .i_enable     (w_rx_en),
    .i_clear      (w_rx_clear),
    .o_word       (w_rx_word),
    .o_byte_count (w_rx_count),
    .o_word_valid (w_rx_valid),
    .o_sym_err    (w_sym_err)
  );

  assign w_rx_en   = ((r_state == ST_XTX) || (r_state == ST_XRX)) && (w_rx_count < 5'd16);
  assign w_timeout = TO_EN && (r_cnt == TO_LAST);

  // A write to word 0 in the go cycle must reach the very first LOAD byte.
  assign w_first_byte = (wr_en && (wr_addr == 4'd0)) ? wr_data[127:120] : r_buf[0][127:120];

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word_idx;
    w_byte_nxt  = r_byte_idx;
    w_cnt_nxt   = r_cnt + 24'd1;
    w_s_out_nxt = symbol_idle;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_go_acc    = 1'b0;
    w_to_err    = 1'b0;
    w_rx_clear  = 1'b0;
    w_rx_wr     = 1'b0;
    w_tx_word   = '0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        if (go) begin
          w_go_acc    = 1'b1;
          w_state_nxt = ST_LOAD;
          w_word_nxt  = '0;
          w_byte_nxt  = '0;
          w_busy_nxt  = 1'b1;
          w_s_out_nxt = {1'b0, w_first_byte};
        end
      end
      ST_LOAD: begin
        if (r_byte_idx != 4'd15) begin
          w_byte_nxt = r_byte_idx + 4'd1;
        end else begin
          w_byte_nxt = '0;
          if (r_word_idx != LAST_WORD) begin
            w_word_nxt = r_word_idx + 4'd1;
          end else begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = '0;
          end
        end
        if (w_state_nxt == ST_LOAD) begin
          w_tx_word   = r_buf[w_word_nxt] << {w_byte_nxt, 3'b000};
          w_s_out_nxt = {1'b0, w_tx_word[127:120]};
        end
      end
      ST_GAP: begin
        if (r_cnt == 24'd1) begin
          w_state_nxt = ST_START;
          w_s_out_nxt = symbol_start;
        end
      end
      ST_START: begin
        w_state_nxt = ST_WAIT_FIN;
        w_cnt_nxt   = '0;
      end
      ST_WAIT_FIN: begin
        if (s_in == symbol_finished) begin
          w_state_nxt = ST_INIT;
          w_s_out_nxt = symbol_init;
        end else if (w_timeout) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_to_err    = 1'b1;
        end
      end
      ST_INIT: begin
        w_state_nxt = ST_XTX;
        w_word_nxt  = '0;
        w_byte_nxt  = '0;
        w_cnt_nxt   = '0;
        w_rx_clear  = 1'b1;
        w_s_out_nxt = 9'h000;
      end
      ST_XTX: begin
        if (w_timeout) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_to_err    = 1'b1;
        end else if (r_byte_idx == 4'd15) begin
          w_state_nxt = ST_XRX;
        end else begin
          w_byte_nxt  = r_byte_idx + 4'd1;
          w_s_out_nxt = 9'h000;
        end
      end
      ST_XRX: begin
        if (w_rx_valid) begin
          w_rx_wr = 1'b1;
          if (r_word_idx == LAST_WORD) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_XTX;
            w_word_nxt  = r_word_idx + 4'd1;
            w_byte_nxt  = '0;
            w_cnt_nxt   = '0;
            w_rx_clear  = 1'b1;
            w_s_out_nxt = 9'h000;
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_to_err    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state    <= ST_IDLE;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_cnt      <= '0;
      r_s_out    <= symbol_idle;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_idx <= w_word_nxt;
      r_byte_idx <= w_byte_nxt;
      r_cnt      <= w_cnt_nxt;
      r_s_out    <= w_s_out_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      if (w_go_acc) begin
        r_error <= 1'b0;
      end else if (w_to_err || (r_busy && w_sym_err)) begin
        r_error <= 1'b1;
      end
    end
  end

  // Host writes are only possible while idle, so they never collide with readback.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < NWORDS; i++) r_buf[i] <= '0;
    end else if (w_rx_wr) begin
      r_buf[r_word_idx] <= w_rx_word;
    end else if (wr_en && !r_busy && ({1'b0, wr_addr} < NW5)) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  assign rd_data = ({1'b0, rd_addr} < NW5) ? r_buf[rd_addr] : '0;
  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_error;
  assign s_out   = r_s_out;

endmodule

// File: tb/tb_cn_link_host.sv
// Directed bench for cn_link_host with a behavioural cn_core link model.
module tb_cn_link_host;
  import cn_link_host_pkg::*;

  localparam int NW = 13;

  logic         clk = 1'b0;
  logic         reset_l;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [127:0] wr_data;
  logic [3:0]   rd_addr;
  logic [127:0] rd_data;
  logic         go;
  logic         busy, done, error;
  logic [8:0]   s_out;
  logic [8:0]   s_in;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int fin_delay  = -1;
  int err_word   = -1;
  int stall_word = -1;

  cn_link_host #(.NWORDS(NW), .TIMEOUT_CYCLES(1000)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .go      (go),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .s_out   (s_out),
    .s_in    (s_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rx_exp(input int w);
    logic [127:0] v = '0;
    for (int k = 0; k < 16; k++) v = {v[119:0], 8'(8'hA0 + w + k)};
    return v;
  endfunction

  function automatic logic [127:0] ld_exp(input int w);
    return {16{8'(w + 1)}};
  endfunction

  task automatic write_word(input int addr, input logic [127:0] data);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < NW; i++) write_word(i, ld_exp(i));
  endtask

  task automatic read_chk(input string tag, input int addr, input logic [127:0] exp);
    rd_addr = 4'(addr);
    #1;
    check_vec(tag, rd_data, exp);
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic wait_sym(input logic [8:0] sym, input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (s_out == sym) seen = 1'b1;
    end
  endtask

  // Core side of the readback: echo 16 bytes per word after its 16 TX bytes.
  task automatic core_readback();
    for (int w = 0; w < NW; w++) begin
      int n = 0;
      while (n < 16) begin
        @(negedge clk);
        if (!busy) return;
        if (!s_out[8]) n++;
      end
      if (w == stall_word) repeat (2000) @(negedge clk);
      if (!busy) return;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (w == err_word && k == 8) begin
          s_in = 9'h1FF;
          @(negedge clk);
        end
        s_in = {1'b0, 8'(8'hA0 + w + k)};
      end
      @(negedge clk);
      s_in = symbol_idle;
    end
  endtask

  initial begin : core_model
    s_in = symbol_idle;
    forever begin
      @(negedge clk);
      if (reset_l === 1'b1 && s_out == symbol_start && fin_delay >= 0) begin
        repeat (fin_delay) @(negedge clk);
        s_in = symbol_finished;
        @(negedge clk);
        s_in = symbol_idle;
        core_readback();
      end
    end
  end

  initial begin : main
    logic [127:0] acc;
    logic         ctl;
    bit           seen;
    int           t0;

    reset_l = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; go = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_s_out", s_out, symbol_idle);
    check_vec("rst_busy", busy, 0);
    check_vec("rst_done", done, 0);
    check_vec("rst_error", error, 0);
    check_vec("rst_buf0", rd_data, 0);
    reset_l = 1'b1;
    @(posedge clk); #1;

    load_all();
    read_chk("ld_buf5", 5, {16{8'h06}});
    read_chk("rd_oob13", 13, 0);
    @(posedge clk); #1;

    // Normal job: full load stream, 500-cycle core, full readback.
    fin_delay = 500;
    pulse_go();
    ctl = 1'b0;
    for (int w = 0; w < NW; w++) begin
      acc = '0;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        acc = {acc[119:0], s_out[7:0]};
        ctl = ctl | s_out[8];
      end
      check_vec($sformatf("load_w%0d", w), acc, ld_exp(w));
    end
    check_vec("load_databit", ctl, 0);
    @(negedge clk); check_vec("gap_idle0", s_out, symbol_idle);
    @(negedge clk); check_vec("gap_idle1", s_out, symbol_idle);
    @(negedge clk); check_vec("start_sym", s_out, symbol_start);
    wait_done(5000, seen);
    check_vec("norm_done_seen", seen, 1);
    check_vec("norm_error", error, 0);
    check_vec("norm_busy", busy, 0);
    @(posedge clk); #1;
    check_vec("norm_done_pulse", done, 0);
    read_chk("rx_w0_const", 0, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    read_chk("rx_w12_const", 12, 128'hACADAEAFB0B1B2B3B4B5B6B7B8B9BABB);
    for (int w = 1; w < NW - 1; w++) read_chk($sformatf("rx_w%0d", w), w, rx_exp(w));
    @(posedge clk); #1;

    // FINISHED never arrives; host activity while busy is ignored.
    load_all();
    fin_delay = -1;
    pulse_go();
    wait_sym(symbol_start, 400, seen);
    check_vec("to_start_seen", seen, 1);
    t0 = cyc;
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = '1; go = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; go = 1'b0;
    wait_done(2000, seen);
    check_vec("to_done_seen", seen, 1);
    check_vec("to_latency", 32'(cyc - t0), 32'd1001);
    check_vec("to_error", error, 1);
    check_vec("to_busy", busy, 0);
    check_vec("to_s_out", s_out, symbol_idle);
    @(posedge clk); #1;
    check_vec("to_done_pulse", done, 0);
    repeat (3) @(posedge clk);
    #1;
    check_vec("to_no_restart", busy, 0);
    read_chk("to_buf0_kept", 0, ld_exp(0));
    @(posedge clk); #1;

    // Illegal symbol mid-readback: error flagged, readback completes.
    fin_delay = 500;
    err_word  = 6;
    pulse_go();
    check_vec("err_clear_on_go", error, 0);
    wait_done(5000, seen);
    check_vec("se_done_seen", seen, 1);
    check_vec("se_error", error, 1);
    @(posedge clk); #1;
    err_word = -1;
    for (int w = 0; w < NW; w++) read_chk($sformatf("se_rx_w%0d", w), w, rx_exp(w));
    @(posedge clk); #1;

    // Word 4 return stalls past the word timeout.
    load_all();
    fin_delay  = 50;
    stall_word = 4;
    pulse_go();
    wait_done(6000, seen);
    check_vec("st_done_seen", seen, 1);
    check_vec("st_error", error, 1);
    @(posedge clk); #1;
    read_chk("st_buf3_new", 3, rx_exp(3));
    read_chk("st_buf4_kept", 4, ld_exp(4));
    read_chk("st_buf12_kept", 12, ld_exp(12));
    repeat (2100) @(posedge clk);
    #1;
    stall_word = -1;

    // Write and go in one cycle, then reset in the middle of LOAD.
    fin_delay = -1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 128'h112233445566778899AABBCCDDEEFF00; go = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; go = 1'b0;
    check_vec("wg_byte0", s_out, 9'h011);
    @(posedge clk); #1;
    check_vec("wg_byte1", s_out, 9'h022);
    check_vec("wg_busy", busy, 1);
    rd_addr = 4'd0;
    @(negedge clk);
    reset_l = 1'b0;
    #1;
    check_vec("mr_s_out", s_out, symbol_idle);
    check_vec("mr_busy", busy, 0);
    check_vec("mr_buf0", rd_data, 0);
    read_chk("mr_buf12", 12, 0);
    @(posedge clk); #3;
    reset_l = 1'b1;
    @(posedge clk); #1;
    check_vec("mr_after_idle", s_out, symbol_idle);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
